mem_stg: RTL and testbench

MEM_STG -- requirements
Module: mem_stg

---
 rtl/mem_stg.sv | 190 +++++++++++++++++++
 tb/tb_mem_stg.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stg.sv
// mem_stg: MIPS memory stage. Holds one packet from exec, performs the data
// memory access (byte/half/word, aligned lanes, sign/zero extension), then
// hands the result to writeback.
// Optional build macro: MEM_MISALIGN_CHK_EN -- traps misaligned HALF/WORD
// accesses (no memory request, no register write, one-cycle mem_err pulse).

package mips_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_sz_t;

  typedef struct packed {
    logic    jmp_vld;
    word_t   addr;
    mem_op_t mem_op;
    mem_sz_t mem_sz;
    logic    sgnd;
    logic    dst_vld;
    reg_t    dst_reg;
    word_t   data;
  } exec_mem_pkt_t;

  typedef struct packed {
    logic  dst_vld;
    reg_t  dst_reg;
    word_t data;
  } mem_wb_pkt_t;

  typedef struct packed {
    logic dst_vld;
    reg_t dst_reg;
    logic busy;
  } mem_haz_pkt_t;
endpackage

module mem_stg
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          exec_mem_vld,
  output logic          exec_mem_rdy,
  input  exec_mem_pkt_t exec_mem_pkt,
  output logic          mem_wb_vld,
  input  logic          mem_wb_rdy,
  output mem_wb_pkt_t   mem_wb_pkt,
  output logic          dmem_req_vld,
  input  logic          dmem_req_rdy,
  output logic          dmem_req_we,
  output word_t         dmem_req_addr,
  output logic [3:0]    dmem_req_be,
  output word_t         dmem_req_wdata,
  input  logic          dmem_rsp_vld,
  input  word_t         dmem_rsp_data,
  output logic          mem_jmp_vld,
  output word_t         mem_jmp_addr,
  output mem_haz_pkt_t  mem_haz_pkt,
  output logic          mem_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state;
  exec_mem_pkt_t hold_p0;
  exec_mem_pkt_t acc_pkt;
  logic [1:0]    acc_state;
  logic          accept;
  logic          is_mem;
  logic          misalign;

  // Byte enables for the addressed lanes of the aligned word.
  function automatic logic [3:0] lane_be(input mem_sz_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << lo;
      SZ_HALF: lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the enables alone pick the target.
  function automatic word_t store_data(input mem_sz_t sz, input word_t d);
    case (sz)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic word_t load_fmt(input mem_sz_t sz, input logic sgnd,
                                     input logic [1:0] lo, input word_t raw);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = raw[{lo, 3'b000} +: 8];
    h_s = lo[1] ? raw[31:16] : raw[15:0];
    case (sz)
      SZ_BYTE: load_fmt = sgnd ? word_t'(32'(b_s)) : {24'h0, b_s};
      SZ_HALF: load_fmt = sgnd ? word_t'(32'(h_s)) : {16'h0, h_s};
      default: load_fmt = raw;
    endcase
  endfunction

  assign exec_mem_rdy = (state == ST_IDLE) || ((state == ST_DONE) && mem_wb_rdy);
  assign accept       = exec_mem_vld && exec_mem_rdy;
  assign is_mem       = (exec_mem_pkt.mem_op == OP_LOAD) || (exec_mem_pkt.mem_op == OP_STORE);

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = is_mem &&
                    (((exec_mem_pkt.mem_sz == SZ_HALF) && exec_mem_pkt.addr[0]) ||
                     ((exec_mem_pkt.mem_sz != SZ_BYTE) && (exec_mem_pkt.mem_sz != SZ_HALF) &&
                      (exec_mem_pkt.addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Shape an accepted packet: stores and trapped accesses never write a register.
  always_comb begin
    acc_pkt = exec_mem_pkt;
    if ((exec_mem_pkt.mem_op == OP_STORE) || misalign) acc_pkt.dst_vld = 1'b0;
    acc_state = (is_mem && !misalign) ? ST_REQ : ST_DONE;
  end

  // Stage p0: held packet and access sequencing; jmp_vld survives only its first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hold_p0 <= '0;
    end else if (accept) begin
      state   <= acc_state;
      hold_p0 <= acc_pkt;
    end else begin
      hold_p0.jmp_vld <= 1'b0;
      case (state)
        ST_REQ:  if (dmem_req_rdy) state <= (hold_p0.mem_op == OP_STORE) ? ST_DONE : ST_WAIT;
        ST_WAIT: if (dmem_rsp_vld) begin
                   hold_p0.data <= load_fmt(hold_p0.mem_sz, hold_p0.sgnd,
                                            hold_p0.addr[1:0], dmem_rsp_data);
                   state        <= ST_DONE;
                 end
        ST_DONE: if (mem_wb_rdy) state <= ST_IDLE;
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  // One-cycle error pulse for each trapped access.
  always_ff @(posedge clk) begin
    if (reset) mem_err <= 1'b0;
    else       mem_err <= accept && misalign;
  end
`else
  assign mem_err = 1'b0;
`endif

  assign mem_jmp_vld    = hold_p0.jmp_vld;
  assign mem_jmp_addr   = hold_p0.addr;

  assign mem_wb_vld     = (state == ST_DONE);
  assign dmem_req_vld   = (state == ST_REQ);
  assign dmem_req_we    = (hold_p0.mem_op == OP_STORE);
  assign dmem_req_addr  = {hold_p0.addr[31:2], 2'b00};
  assign dmem_req_be    = lane_be(hold_p0.mem_sz, hold_p0.addr[1:0]);
  assign dmem_req_wdata = store_data(hold_p0.mem_sz, hold_p0.data);

  // Writeback and hazard views of the held packet.
  always_comb begin
    mem_wb_pkt.dst_vld  = hold_p0.dst_vld;
    mem_wb_pkt.dst_reg  = hold_p0.dst_reg;
    mem_wb_pkt.data     = hold_p0.data;
    mem_haz_pkt.dst_vld = (state != ST_IDLE) && hold_p0.dst_vld;
    mem_haz_pkt.dst_reg = (state != ST_IDLE) ? hold_p0.dst_reg : 5'd0;
    mem_haz_pkt.busy    = (state == ST_REQ) || (state == ST_WAIT);
  end

endmodule

// File: tb/tb_mem_stg.sv
// tb_mem_stg: scoreboard bench for mem_stg. Expected results come from a
// byte-addressed reference memory; the bench also models the data memory.
`timescale 1ns/1ps
module tb_mem_stg;
  import mips_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          exec_mem_vld;
  logic          exec_mem_rdy;
  exec_mem_pkt_t exec_mem_pkt;
  logic          mem_wb_vld;
  logic          mem_wb_rdy;
  mem_wb_pkt_t   mem_wb_pkt;
  logic          dmem_req_vld;
  logic          dmem_req_rdy;
  logic          dmem_req_we;
  logic [31:0]   dmem_req_addr;
  logic [3:0]    dmem_req_be;
  logic [31:0]   dmem_req_wdata;
  logic          dmem_rsp_vld;
  logic [31:0]   dmem_rsp_data;
  logic          mem_jmp_vld;
  logic [31:0]   mem_jmp_addr;
  mem_haz_pkt_t  mem_haz_pkt;
  logic          mem_err;

  mem_stg dut (
    .clk(clk), .reset(reset),
    .exec_mem_vld(exec_mem_vld), .exec_mem_rdy(exec_mem_rdy), .exec_mem_pkt(exec_mem_pkt),
    .mem_wb_vld(mem_wb_vld), .mem_wb_rdy(mem_wb_rdy), .mem_wb_pkt(mem_wb_pkt),
    .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_vld(dmem_rsp_vld), .dmem_rsp_data(dmem_rsp_data),
    .mem_jmp_vld(mem_jmp_vld), .mem_jmp_addr(mem_jmp_addr),
    .mem_haz_pkt(mem_haz_pkt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  mem_wb_pkt_t   sb_q[$];
  req_t          req_q[$];
  int            wb_cyc_q[$];
  logic [7:0]    ref_mem [256];
  logic [31:0]   dmem_words [64];
  mem_wb_pkt_t   last_wb;
  bit            mon_en = 0;
  int            cyc = 0;
  int            wb_mode = 0;
  int            force_stall = 0;
  bit            zero_wait = 0;
  bit            rsp_block = 0;
  bit            rsp_due = 0;
  int            rsp_cnt = 0;
  logic [31:0]   rsp_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input mem_sz_t sz);
    if (sz == SZ_BYTE) return 1;
    if (sz == SZ_HALF) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input exec_mem_pkt_t p);
`ifdef MEM_MISALIGN_CHK_EN
    int nb = nbytes(p.mem_sz);
    if (p.mem_op == OP_NONE) return 0;
    return (int'(p.addr[7:0]) % nb) != 0;
`else
    return (p.mem_op == OP_NONE) && 1'b0;
`endif
  endfunction

  // Reference: byte-addressed memory, natural-alignment lane choice, plain extension.
  function automatic void model(input exec_mem_pkt_t p, output mem_wb_pkt_t r,
                                output req_t q, output bit has_req);
    int nb = nbytes(p.mem_sz);
    int base = int'(p.addr[7:0]) & ~(nb - 1);
    logic [31:0] v = '0;
    r.dst_vld = p.dst_vld;
    r.dst_reg = p.dst_reg;
    r.data    = p.data;
    has_req   = 0;
    q         = '0;
    if (p.mem_op == OP_NONE) return;
    if (is_misaligned(p)) begin
      r.dst_vld = 0;
      return;
    end
    has_req = 1;
    q.we    = (p.mem_op == OP_STORE);
    q.addr  = p.addr & 32'hFFFF_FFFC;
    q.be    = 4'(((1 << nb) - 1) << (base % 4));
    if (nb == 1)      q.wdata = {24'h0, p.data[7:0]} * 32'h0101_0101;
    else if (nb == 2) q.wdata = {16'h0, p.data[15:0]} * 32'h0001_0001;
    else              q.wdata = p.data;
    if (p.mem_op == OP_STORE) begin
      for (int i = 0; i < nb; i++) ref_mem[base + i] = 8'(p.data >> (8 * i));
      r.dst_vld = 0;
    end else begin
      for (int i = 0; i < nb; i++) v = v | ({24'h0, ref_mem[base + i]} << (8 * i));
      if (p.sgnd && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      r.data = v;
    end
  endfunction

  function automatic exec_mem_pkt_t mk(input mem_op_t op, input mem_sz_t sz, input bit sg,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input bit dv, input logic [4:0] dr, input bit j);
    exec_mem_pkt_t p;
    p.jmp_vld = j; p.addr = a; p.mem_op = op; p.mem_sz = sz; p.sgnd = sg;
    p.dst_vld = dv; p.dst_reg = dr; p.data = d;
    return p;
  endfunction

  // Driver: present a packet, wait for the handshake, record expectations.
  task automatic issue(input exec_mem_pkt_t p);
    int n = 0;
    mem_wb_pkt_t r;
    req_t q;
    bit hr;
    exec_mem_vld = 1'b1;
    exec_mem_pkt = p;
    @(negedge clk);
    while (!exec_mem_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!exec_mem_rdy) begin
      chk("accept_timeout", 0, 1);
      exec_mem_vld = 1'b0;
      return;
    end
    model(p, r, q, hr);
    sb_q.push_back(r);
    if (hr) req_q.push_back(q);
    @(posedge clk); #1;
    exec_mem_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Writeback monitor: pop and compare on every handshake.
  mem_wb_pkt_t wb_exp;
  initial forever begin
    @(negedge clk);
    if (mon_en && !reset && mem_wb_vld && mem_wb_rdy) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        wb_exp = sb_q.pop_front();
        chk("wb_pkt", mem_wb_pkt, wb_exp);
        last_wb = mem_wb_pkt;
        wb_cyc_q.push_back(cyc);
      end
    end
  end

  // Writeback ready generator.
  initial begin
    mem_wb_rdy = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (wb_mode)
        0:       mem_wb_rdy = ($urandom_range(0, 3) != 0);
        1:       mem_wb_rdy = 1'b1;
        default: mem_wb_rdy = 1'b0;
      endcase
    end
  end

  // Pulse monitor: jump redirect and error each last exactly the cycle after acceptance.
  bit jexp = 0;
  bit eexp = 0;
  logic [31:0] jaddr = '0;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("jmp_vld", mem_jmp_vld, jexp);
      if (jexp) chk("jmp_addr", mem_jmp_addr, jaddr);
      chk("mem_err", mem_err, eexp);
    end
    jexp  = !reset && exec_mem_vld && exec_mem_rdy && exec_mem_pkt.jmp_vld;
    jaddr = exec_mem_pkt.addr;
    eexp  = !reset && exec_mem_vld && exec_mem_rdy && is_misaligned(exec_mem_pkt);
  end

  // Data memory model: checks requests, applies stores, returns load data.
  bit   stalled = 0;
  req_t prev_req, cur_req, exp_req;
  initial begin
    dmem_req_rdy  = 1'b0;
    dmem_rsp_vld  = 1'b0;
    dmem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && dmem_req_vld) begin
        cur_req = '{dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata};
        if (stalled) chk("req_stable", cur_req, prev_req);
        if (dmem_req_rdy) begin
          stalled = 0;
          if (req_q.size() == 0) chk("req_unexpected", 1, 0);
          else begin
            exp_req = req_q.pop_front();
            chk("req_we", dmem_req_we, exp_req.we);
            chk("req_addr", dmem_req_addr, exp_req.addr);
            chk("req_be", dmem_req_be, exp_req.be);
            if (exp_req.we) chk("req_wdata", dmem_req_wdata, exp_req.wdata);
          end
          if (dmem_req_we) begin
            for (int i = 0; i < 4; i++)
              if (dmem_req_be[i])
                dmem_words[dmem_req_addr[7:2]][8*i +: 8] = dmem_req_wdata[8*i +: 8];
          end else begin
            rsp_word = dmem_words[dmem_req_addr[7:2]];
            rsp_due  = 1;
            rsp_cnt  = zero_wait ? 0 : int'($urandom_range(0, 2));
          end
        end else begin
          stalled  = 1;
          prev_req = cur_req;
          if (force_stall > 0) force_stall--;
        end
      end else begin
        stalled = 0;
      end
      @(posedge clk); #2;
      dmem_rsp_vld = 1'b0;
      if (rsp_due && !rsp_block) begin
        if (rsp_cnt == 0) begin
          dmem_rsp_vld  = 1'b1;
          dmem_rsp_data = rsp_word;
          rsp_due       = 0;
        end else rsp_cnt--;
      end
      if (force_stall > 0) dmem_req_rdy = 1'b0;
      else if (zero_wait)  dmem_req_rdy = 1'b1;
      else                 dmem_req_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  exec_mem_pkt_t p;
  int n0, n;
  initial begin
    reset        = 1'b1;
    exec_mem_vld = 1'b0;
    exec_mem_pkt = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)
      dmem_words[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_exec_rdy", exec_mem_rdy, 1);
    chk("rst_wb_vld", mem_wb_vld, 0);
    chk("rst_req_vld", dmem_req_vld, 0);
    chk("rst_jmp_vld", mem_jmp_vld, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_haz", mem_haz_pkt, 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1;
    wb_mode = 1;
    @(posedge clk); #1;

    // NONE op: result visible the cycle after acceptance
    issue(mk(OP_NONE, SZ_WORD, 0, 32'h0, 32'h0000_1234, 1, 5'd5, 0));
    @(negedge clk);
    chk("none_lat_vld", mem_wb_vld, 1);
    chk("none_data", mem_wb_pkt.data, 32'h0000_1234);
    chk("none_reg", mem_wb_pkt.dst_reg, 5);
    drain();

    // LOAD BYTE at 0x103 from word 0x80FF_0000, zero-wait memory
    ref_mem[0] = 8'h00; ref_mem[1] = 8'h00; ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;
    dmem_words[0] = 32'h80FF_0000;
    zero_wait = 1;
    @(posedge clk); #1;
    issue(mk(OP_LOAD, SZ_BYTE, 1, 32'h0000_0103, 32'h0, 1, 5'd7, 0));
    @(negedge clk); chk("load_lat_n1", mem_wb_vld, 0);
    @(negedge clk); chk("load_lat_n2", mem_wb_vld, 0);
    @(negedge clk); chk("load_lat_n3", mem_wb_vld, 1);
    drain();
    chk("lb_signed", last_wb.data, 32'hFFFF_FF80);
    issue(mk(OP_LOAD, SZ_BYTE, 0, 32'h0000_0103, 32'h0, 1, 5'd7, 0));
    drain();
    chk("lb_unsigned", last_wb.data, 32'h0000_0080);
    zero_wait = 0;

    // STORE HALF at 0x202 with three stall cycles
    force_stall = 3;
    issue(mk(OP_STORE, SZ_HALF, 0, 32'h0000_0202, 32'h0000_ABCD, 1, 5'd3, 0));
    drain();
    chk("sh_dst_vld", last_wb.dst_vld, 0);
    chk("sh_mem", dmem_words[0][31:16], 16'hABCD);

    // Back-to-back NONE ops, one result per cycle
    n0 = wb_cyc_q.size();
    for (int i = 0; i < 4; i++) issue(mk(OP_NONE, SZ_WORD, 0, 32'h0, 32'($urandom), 1, 5'(i + 1), 0));
    drain();
    chk("b2b_count", wb_cyc_q.size() - n0, 4);
    if (wb_cyc_q.size() - n0 == 4) chk("b2b_span", wb_cyc_q[n0 + 3] - wb_cyc_q[n0], 3);

    // Writeback stalled: packet held and input not ready
    wb_mode = 2;
    issue(mk(OP_NONE, SZ_WORD, 0, 32'h0, 32'hCAFE_0001, 1, 5'd9, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_wb_vld", mem_wb_vld, 1);
      chk("hold_exec_rdy", exec_mem_rdy, 0);
      chk("hold_data", mem_wb_pkt.data, 32'hCAFE_0001);
    end
    @(posedge clk); #1;
    wb_mode = 1;
    drain();

    // Jump redirect on a held LOAD: single pulse
    issue(mk(OP_LOAD, SZ_WORD, 0, 32'h0040_0010, 32'h0, 1, 5'd4, 1));
    drain();

    // Misaligned WORD load
    issue(mk(OP_LOAD, SZ_WORD, 0, 32'h0000_0101, 32'h0, 1, 5'd6, 0));
    drain();

    // Reset during WAIT, then a stray response
    rsp_block = 1;
    issue(mk(OP_LOAD, SZ_WORD, 0, 32'h0000_0040, 32'h0, 1, 5'd10, 0));
    n = 0;
    while (!rsp_due && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_due) chk("wait_timeout", 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_busy", mem_haz_pkt.busy, 1);
    chk("wait_wb_vld", mem_wb_vld, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    req_q.delete();
    rsp_block = 0;
    @(negedge clk);
    chk("post_rst_rdy", exec_mem_rdy, 1);
    chk("post_rst_haz", mem_haz_pkt, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stray_wb_vld", mem_wb_vld, 0);
    end
    chk("stray_sent", rsp_due, 0);
    @(posedge clk); #1;

    // Randomized traffic
    wb_mode = 0;
    for (int i = 0; i < 300; i++) begin
      p = mk(mem_op_t'($urandom_range(0, 2)), mem_sz_t'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 255)),
             32'($urandom()), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0));
      issue(p);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wb_mode = 1;
    drain();
    chk("final_req_q", req_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
